// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
//   Shared definitions for the Sobel edge-detection control path.
//   - state_t        : sequencing FSM state encoding (5 bits)
//   - read_to_load() : R_PIXELk -> L_PIXELk
//   - load_to_next() : L_PIXELk -> R_PIXEL(k+1), or GRAD after the ninth pixel
// -----------------------------------------------------------------------------
package sobel_pkg;

    typedef enum logic [4:0] {
        IDLE,
        LOAD_PARAM,
        R_PIXEL1, R_PIXEL2, R_PIXEL3, R_PIXEL4, R_PIXEL5,
        R_PIXEL6, R_PIXEL7, R_PIXEL8, R_PIXEL9,
        L_PIXEL1, L_PIXEL2, L_PIXEL3, L_PIXEL4, L_PIXEL5,
        L_PIXEL6, L_PIXEL7, L_PIXEL8, L_PIXEL9,
        GRAD,
        T_GRAD,
        WRITE,
        MOVE,
        SHIFT,
        READ
    } state_t;

    // Once a pixel has been read it is loaded into the matching window slot.
    function automatic state_t read_to_load(input state_t s);
        case (s)
            R_PIXEL1: return L_PIXEL1;
            R_PIXEL2: return L_PIXEL2;
            R_PIXEL3: return L_PIXEL3;
            R_PIXEL4: return L_PIXEL4;
            R_PIXEL5: return L_PIXEL5;
            R_PIXEL6: return L_PIXEL6;
            R_PIXEL7: return L_PIXEL7;
            R_PIXEL8: return L_PIXEL8;
            R_PIXEL9: return L_PIXEL9;
            default:  return IDLE;
        endcase
    endfunction

    // After a window slot is loaded, read the next pixel; the ninth load
    // completes the 3x3 window and hands over to the gradient loop.
    function automatic state_t load_to_next(input state_t s);
        case (s)
            L_PIXEL1: return R_PIXEL2;
            L_PIXEL2: return R_PIXEL3;
            L_PIXEL3: return R_PIXEL4;
            L_PIXEL4: return R_PIXEL5;
            L_PIXEL5: return R_PIXEL6;
            L_PIXEL6: return R_PIXEL7;
            L_PIXEL7: return R_PIXEL8;
            L_PIXEL8: return R_PIXEL9;
            L_PIXEL9: return GRAD;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sobel_controller.sv
// -----------------------------------------------------------------------------
// sobel_controller
//   Top-level Moore sequencing FSM of the Sobel datapath. A run starts on
//   `start`, loads parameters, preloads the 3x3 window with nine read/load
//   pairs, then loops gradient -> total gradient -> write -> move -> shift ->
//   read until a write completes with all_done set.
//
// Ports
//   clk               in   system clock, rising edge
//   n_rst             in   synchronous active-high reset (despite the name)
//   start             in   begin a run, honoured in IDLE only
//   load_done         in   parameter load / window load complete
//   read_data_done    in   single pixel read complete
//   h_done, v_done    in   horizontal / vertical gradient complete
//   calculation_done  in   total gradient complete
//   write_done        in   result pixel written
//   all_done          in   last pixel reached (qualified by write_done)
//   move_done         in   address move complete
//   shift_done        in   window shift complete
//   read_done         in   next column read complete
//   load_initial .. start_read  out  one-hot level requests, decoded from state
// -----------------------------------------------------------------------------
module sobel_controller
    import sobel_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic start,
    input  logic load_done,
    input  logic read_data_done,
    input  logic h_done,
    input  logic v_done,
    input  logic calculation_done,
    input  logic write_done,
    input  logic all_done,
    input  logic move_done,
    input  logic shift_done,
    input  logic read_done,
    output logic load_initial,
    output logic start_i_read,
    output logic start_9_read,
    output logic start_calculation,
    output logic start_t_grad,
    output logic start_write,
    output logic start_move,
    output logic start_shift,
    output logic start_read
);

    state_t state;
    state_t state_next;
    logic   h_seen;
    logic   v_seen;

    // The two gradient engines finish independently; a done counts whether it
    // arrives this cycle or was latched in an earlier GRAD cycle.
    logic   h_ok;
    logic   v_ok;
    assign h_ok = h_seen | h_done;
    assign v_ok = v_seen | v_done;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so every path drives state_next and no
        // latch is inferred.
        state_next = state;
        case (state)
            IDLE:       if (start)            state_next = LOAD_PARAM;
            LOAD_PARAM: if (load_done)        state_next = R_PIXEL1;
            R_PIXEL1, R_PIXEL2, R_PIXEL3, R_PIXEL4, R_PIXEL5,
            R_PIXEL6, R_PIXEL7, R_PIXEL8, R_PIXEL9:
                        if (read_data_done)   state_next = read_to_load(state);
            L_PIXEL1, L_PIXEL2, L_PIXEL3, L_PIXEL4, L_PIXEL5,
            L_PIXEL6, L_PIXEL7, L_PIXEL8, L_PIXEL9:
                        if (load_done)        state_next = load_to_next(state);
            GRAD:       if (h_ok && v_ok)     state_next = T_GRAD;
            T_GRAD:     if (calculation_done) state_next = WRITE;
            WRITE:      if (write_done)       state_next = all_done ? IDLE : MOVE;
            MOVE:       if (move_done)        state_next = SHIFT;
            SHIFT:      if (shift_done)       state_next = READ;
            READ:       if (read_done)        state_next = GRAD;
            default:                          state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and gradient join flags
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state  <= IDLE;
            h_seen <= 1'b0;
            v_seen <= 1'b0;
        end else begin
            state <= state_next;
            // Flags accumulate only while GRAD is held; leaving GRAD (or never
            // being in it) clears them so the next visit starts fresh.
            if (state == GRAD && state_next == GRAD) begin
                h_seen <= h_ok;
                v_seen <= v_ok;
            end else begin
                h_seen <= 1'b0;
                v_seen <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output decode: pure function of state, at most one request high
    // -------------------------------------------------------------------------
    always_comb begin
        load_initial      = 1'b0;
        start_i_read      = 1'b0;
        start_9_read      = 1'b0;
        start_calculation = 1'b0;
        start_t_grad      = 1'b0;
        start_write       = 1'b0;
        start_move        = 1'b0;
        start_shift       = 1'b0;
        start_read        = 1'b0;
        case (state)
            LOAD_PARAM: load_initial = 1'b1;
            R_PIXEL1, R_PIXEL2, R_PIXEL3, R_PIXEL4, R_PIXEL5,
            R_PIXEL6, R_PIXEL7, R_PIXEL8, R_PIXEL9:
                        start_i_read = 1'b1;
            L_PIXEL1, L_PIXEL2, L_PIXEL3, L_PIXEL4, L_PIXEL5,
            L_PIXEL6, L_PIXEL7, L_PIXEL8, L_PIXEL9:
                        start_9_read = 1'b1;
            GRAD:       start_calculation = 1'b1;
            T_GRAD:     start_t_grad      = 1'b1;
            WRITE:      start_write       = 1'b1;
            MOVE:       start_move        = 1'b1;
            SHIFT:      start_shift       = 1'b1;
            READ:       start_read        = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_sobel_controller.sv
// -----------------------------------------------------------------------------
// tb_sobel_controller
//   Directed bench for sobel_controller: a table of {inputs, expected outputs}
//   records applied one clock each, followed by hand-written sequences for
//   flag clearing on reset, mid-run reset and restart on a held start.
// -----------------------------------------------------------------------------
module tb_sobel_controller;

    logic clk = 1'b0;
    logic n_rst, start;
    logic load_done, read_data_done, h_done, v_done, calculation_done;
    logic write_done, all_done, move_done, shift_done, read_done;
    logic load_initial, start_i_read, start_9_read, start_calculation;
    logic start_t_grad, start_write, start_move, start_shift, start_read;

    always #5 clk = ~clk;

    sobel_controller dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .load_done(load_done), .read_data_done(read_data_done),
        .h_done(h_done), .v_done(v_done), .calculation_done(calculation_done),
        .write_done(write_done), .all_done(all_done), .move_done(move_done),
        .shift_done(shift_done), .read_done(read_done),
        .load_initial(load_initial), .start_i_read(start_i_read),
        .start_9_read(start_9_read), .start_calculation(start_calculation),
        .start_t_grad(start_t_grad), .start_write(start_write),
        .start_move(start_move), .start_shift(start_shift),
        .start_read(start_read)
    );

    // done input encoding: {load, read_data, h, v, calc, write, all, move, shift, read}
    localparam logic [9:0] D_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] D_LOAD  = 10'b10_0000_0000;
    localparam logic [9:0] D_RDATA = 10'b01_0000_0000;
    localparam logic [9:0] D_H     = 10'b00_1000_0000;
    localparam logic [9:0] D_V     = 10'b00_0100_0000;
    localparam logic [9:0] D_CALC  = 10'b00_0010_0000;
    localparam logic [9:0] D_WRITE = 10'b00_0001_0000;
    localparam logic [9:0] D_ALL   = 10'b00_0000_1000;
    localparam logic [9:0] D_MOVE  = 10'b00_0000_0100;
    localparam logic [9:0] D_SHIFT = 10'b00_0000_0010;
    localparam logic [9:0] D_READ  = 10'b00_0000_0001;

    // output encoding: {load_initial, i_read, 9_read, calc, t_grad, write, move, shift, read}
    localparam logic [8:0] O_NONE = 9'b0_0000_0000;
    localparam logic [8:0] O_LI   = 9'b1_0000_0000;
    localparam logic [8:0] O_IR   = 9'b0_1000_0000;
    localparam logic [8:0] O_9R   = 9'b0_0100_0000;
    localparam logic [8:0] O_CALC = 9'b0_0010_0000;
    localparam logic [8:0] O_TG   = 9'b0_0001_0000;
    localparam logic [8:0] O_WR   = 9'b0_0000_1000;
    localparam logic [8:0] O_MV   = 9'b0_0000_0100;
    localparam logic [8:0] O_SH   = 9'b0_0000_0010;
    localparam logic [8:0] O_RD   = 9'b0_0000_0001;

    typedef struct {
        bit         rst;
        bit         st;
        logic [9:0] dn;
        logic [8:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    function automatic logic [8:0] outs();
        return {load_initial, start_i_read, start_9_read, start_calculation,
                start_t_grad, start_write, start_move, start_shift, start_read};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: outputs got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive inputs between edges, clock once, then sample 1 time unit later.
    task automatic step(input bit rst, input bit st, input logic [9:0] dn,
                        input logic [8:0] exp, input string name);
        n_rst = rst;
        start = st;
        {load_done, read_data_done, h_done, v_done, calculation_done,
         write_done, all_done, move_done, shift_done, read_done} = dn;
        @(posedge clk);
        #1;
        check(name, outs(), exp);
    endtask

    function automatic void add(input bit rst, input bit st, input logic [9:0] dn,
                                input logic [8:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.st = st; v.dn = dn; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    // IDLE -> LOAD_PARAM -> nine read/load pairs -> GRAD
    task automatic preload(input string tag);
        step(0, 1, D_NONE, O_LI, {tag, "_start"});
        step(0, 0, D_LOAD, O_IR, {tag, "_param"});
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, D_RDATA, O_9R, $sformatf("%s_rd%0d", tag, k));
            step(0, 0, D_LOAD, (k == 9) ? O_CALC : O_IR, $sformatf("%s_ld%0d", tag, k));
        end
    endtask

    initial begin
        n_rst = 1'b1;
        start = 1'b1;
        {load_done, read_data_done, h_done, v_done, calculation_done,
         write_done, all_done, move_done, shift_done, read_done} = D_NONE;

        // ---------------- vector table ----------------
        add(1, 1, D_NONE,  O_NONE, "reset_edge1");
        add(1, 1, D_NONE,  O_NONE, "reset_edge2");
        add(0, 1, D_NONE,  O_LI,   "start_after_reset");
        add(0, 1, D_NONE,  O_LI,   "start_ignored_in_load_param");
        add(0, 0, D_LOAD,  O_IR,   "param_loaded");
        for (int k = 1; k <= 9; k++) begin
            add(0, 0, D_RDATA, O_9R, $sformatf("pixel_read_%0d", k));
            if (k == 2)
                add(0, 0, D_NONE, O_9R, "l_pixel_waits");
            add(0, 0, D_LOAD, (k == 9) ? O_CALC : O_IR, $sformatf("pixel_load_%0d", k));
            if (k == 3)
                add(0, 0, D_LOAD, O_IR, "held_load_done_single_advance");
        end
        add(0, 0, D_NONE,  O_CALC, "grad_c1");
        add(0, 0, D_NONE,  O_CALC, "grad_c2");
        add(0, 0, D_H,     O_CALC, "grad_c3_h_only");
        add(0, 0, D_MOVE,  O_CALC, "grad_spurious_move");
        add(0, 0, D_NONE,  O_CALC, "grad_c5");
        add(0, 0, D_NONE,  O_CALC, "grad_c6");
        add(0, 0, D_V,     O_TG,   "grad_c7_v_joins");
        add(0, 0, D_CALC,  O_WR,   "t_grad_done");
        add(0, 0, D_ALL,   O_WR,   "all_done_without_write");
        add(0, 0, D_NONE,  O_WR,   "write_waits");
        add(0, 0, D_WRITE, O_MV,   "write_not_last");
        add(0, 0, D_MOVE,  O_SH,   "move_done");
        add(0, 0, D_SHIFT, O_RD,   "shift_done");
        add(0, 0, D_READ,  O_CALC, "read_done_loop");
        add(0, 0, D_V,     O_CALC, "grad2_v_only_flags_cleared");
        add(0, 0, D_H,     O_TG,   "grad2_h_joins");
        add(0, 0, D_CALC,  O_WR,   "t_grad2_done");
        add(0, 0, D_CALC,  O_WR,   "held_calc_no_double_advance");
        add(0, 0, D_WRITE, O_MV,   "write2_not_last");
        add(0, 0, D_MOVE,  O_SH,   "move2_done");
        add(0, 0, D_SHIFT, O_RD,   "shift2_done");
        add(0, 0, D_READ,  O_CALC, "read2_done");
        add(0, 0, D_H | D_V, O_TG, "grad3_same_cycle");
        add(0, 0, D_CALC,  O_WR,   "t_grad3_done");
        add(0, 0, D_WRITE | D_ALL, O_NONE, "last_write_to_idle");
        add(0, 0, D_NONE,  O_NONE, "idle_holds");
        add(0, 0, D_LOAD,  O_NONE, "idle_ignores_load_done");

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].st, vecs[i].dn, vecs[i].exp, vecs[i].name);

        // ---------------- reset clears gradient flags, mid-run reset ----------
        preload("runA");
        step(0, 0, D_H,    O_CALC, "runA_h_only");
        step(1, 0, D_NONE, O_NONE, "runA_reset_in_grad");
        preload("runB");
        step(0, 0, D_V,    O_CALC, "runB_v_only_flags_reset");
        step(0, 0, D_H,    O_TG,   "runB_h_joins");
        step(1, 1, D_CALC, O_NONE, "runB_reset_in_t_grad");

        // ---------------- held start at WRITE -> IDLE exit ----------
        preload("runC");
        step(0, 0, D_H | D_V, O_TG, "runC_join");
        step(0, 0, D_CALC, O_WR,   "runC_t_grad_done");
        step(0, 1, D_WRITE | D_ALL, O_NONE, "runC_exit_with_start");
        step(0, 1, D_NONE, O_LI,   "runC_restart_next_cycle");
        step(1, 0, D_NONE, O_NONE, "final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
